// File: rtl/mmul_parallel_engine_ctrl_pkg.sv
// Shared types and default widths for the MMUL_PARALLEL engine control block.
// Holds the controller state encoding and a helper naming the watchdog-guarded states.
package mmul_parallel_engine_ctrl_pkg;

  localparam int DEF_ITER_W = 16;
  localparam int DEF_CNT_W  = 12;
  localparam int DEF_TO_W   = 20;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    WAIT_RDY,
    START,
    RUN,
    CHECK,
    DONE,
    ABORT,
    CLEAR_ONLY
  } ctrl_state_t;

  // The watchdog only counts while waiting on the engine.
  function automatic logic is_wait_state(ctrl_state_t s);
    return (s == WAIT_RDY) || (s == RUN);
  endfunction

endpackage

// File: rtl/mmul_parallel_engine_ctrl_watchdog.sv
// Cycle counter with synchronous reload and limit compare.
// A zero limit disables expiry; the count saturates so it never wraps back under the limit.
module mmul_parallel_watchdog #(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expire
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // A reload in the same cycle means the awaited event arrived, so it masks expiry.
  assign expire = enable && !load && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/mmul_parallel_engine_ctrl.sv
// Initiator side of the MMUL_PARALLEL engine control channel: runs a job of N engine
// iterations, cross-checks the engine done-counter and guards every wait with a watchdog.
module mmul_parallel_engine_ctrl
  import mmul_parallel_engine_ctrl_pkg::*;
#(
  parameter int ITER_W = DEF_ITER_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              job_trigger_i,
  input  logic [ITER_W-1:0] job_iters_i,
  input  logic [TO_W-1:0]   timeout_i,
  input  logic              soft_clear_i,
  output logic              eng_start_o,
  output logic              eng_clear_o,
  input  logic              eng_done_i,
  input  logic              eng_idle_i,
  input  logic              eng_ready_i,
  input  logic [CNT_W-1:0]  eng_cnt_i,
  output logic              busy_o,
  output logic              job_done_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              err_timeout_o,
  output logic              err_cnt_o,
  output ctrl_state_t       state_o
);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [ITER_W-1:0] iters_q;
  logic [TO_W-1:0]   timeout_q;
  logic [ITER_W-1:0] iter_inc;
  logic              eng_go;
  logic              new_job;
  logic              zero_job;
  logic              wd_en;
  logic              wd_load;
  logic              wd_expire;

  assign state_o  = state;
  assign eng_go   = eng_ready_i | eng_idle_i;
  assign new_job  = (state == IDLE) && job_trigger_i && !soft_clear_i;
  assign zero_job = new_job && (job_iters_i == '0);
  assign iter_inc = (iter_cnt_o == '1) ? iter_cnt_o : iter_cnt_o + 1'b1;

  // Reload on every exit from a guarded state so each wait starts from zero.
  assign wd_en   = is_wait_state(state);
  assign wd_load = soft_clear_i || !wd_en
                 || ((state == WAIT_RDY) && eng_go)
                 || ((state == RUN) && eng_done_i);

  mmul_parallel_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (wd_load),
    .enable (wd_en),
    .limit  (timeout_q),
    .expire (wd_expire)
  );

  always_comb begin
    state_nxt = state;
    if (soft_clear_i) begin
      state_nxt = CLEAR_ONLY;
    end else begin
      case (state)
        IDLE:       if (new_job && !zero_job) state_nxt = CLEAR;
        CLEAR:      state_nxt = WAIT_RDY;
        WAIT_RDY: begin
          if (eng_go)         state_nxt = START;
          else if (wd_expire) state_nxt = ABORT;
        end
        START:      state_nxt = RUN;
        RUN: begin
          // A done arriving with the expiry cycle takes precedence.
          if (eng_done_i)     state_nxt = (iter_inc == iters_q) ? CHECK : WAIT_RDY;
          else if (wd_expire) state_nxt = ABORT;
        end
        CHECK:      state_nxt = DONE;
        DONE:       state_nxt = IDLE;
        ABORT:      state_nxt = IDLE;
        CLEAR_ONLY: state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      eng_start_o   <= 1'b0;
      eng_clear_o   <= 1'b0;
      busy_o        <= 1'b0;
      job_done_o    <= 1'b0;
      iters_q       <= '0;
      timeout_q     <= '0;
      iter_cnt_o    <= '0;
      err_timeout_o <= 1'b0;
      err_cnt_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      eng_start_o <= (state_nxt == START);
      eng_clear_o <= (state_nxt == CLEAR) || (state_nxt == ABORT) || (state_nxt == CLEAR_ONLY);
      busy_o      <= (state_nxt != IDLE);
      job_done_o  <= (state_nxt == DONE) || (state_nxt == ABORT) || zero_job;

      if (soft_clear_i) begin
        iter_cnt_o    <= '0;
        err_timeout_o <= 1'b0;
        err_cnt_o     <= 1'b0;
      end else begin
        if (wd_expire) err_timeout_o <= 1'b1;
        case (state)
          IDLE: begin
            if (new_job) begin
              err_timeout_o <= 1'b0;
              err_cnt_o     <= 1'b0;
              if (!zero_job) begin
                iters_q    <= job_iters_i;
                timeout_q  <= timeout_i;
                iter_cnt_o <= '0;
              end
            end
          end
          RUN: begin
            if (eng_done_i) iter_cnt_o <= iter_inc;
          end
          CHECK: begin
            // The engine counter wraps at its own width, so compare modulo 2^CNT_W.
            if (eng_cnt_i != CNT_W'(iters_q)) err_cnt_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmul_parallel_engine_ctrl.sv
// Bench for mmul_parallel_engine_ctrl: behavioural engine model plus per-scenario tasks
// whose expected event counts and cycle numbers come from the job timing rules.
module tb_mmul_parallel_engine_ctrl;
  import mmul_parallel_engine_ctrl_pkg::*;

  localparam int ITER_W = 16;
  localparam int CNT_W  = 12;
  localparam int TO_W   = 20;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              job_trigger_i = 1'b0;
  logic [ITER_W-1:0] job_iters_i = '0;
  logic [TO_W-1:0]   timeout_i = '0;
  logic              soft_clear_i = 1'b0;
  logic              eng_start_o;
  logic              eng_clear_o;
  logic              eng_done_i = 1'b0;
  logic              eng_idle_i = 1'b1;
  logic              eng_ready_i = 1'b1;
  logic [CNT_W-1:0]  eng_cnt_i = '0;
  logic              busy_o;
  logic              job_done_o;
  logic [ITER_W-1:0] iter_cnt_o;
  logic              err_timeout_o;
  logic              err_cnt_o;
  ctrl_state_t       dbg_state;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int start_cnt, clear_cnt, jdone_cnt;
  int start_cyc, clear_first, clear_last, jdone_cyc, abort_cyc;
  bit busy_seen;

  int done_delay = 5;
  bit done_en    = 1'b1;
  bit spurious   = 1'b0;
  int cd         = 0;

  mmul_parallel_engine_ctrl #(
    .ITER_W (ITER_W),
    .CNT_W  (CNT_W),
    .TO_W   (TO_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .job_trigger_i (job_trigger_i),
    .job_iters_i   (job_iters_i),
    .timeout_i     (timeout_i),
    .soft_clear_i  (soft_clear_i),
    .eng_start_o   (eng_start_o),
    .eng_clear_o   (eng_clear_o),
    .eng_done_i    (eng_done_i),
    .eng_idle_i    (eng_idle_i),
    .eng_ready_i   (eng_ready_i),
    .eng_cnt_i     (eng_cnt_i),
    .busy_o        (busy_o),
    .job_done_o    (job_done_o),
    .iter_cnt_o    (iter_cnt_o),
    .err_timeout_o (err_timeout_o),
    .err_cnt_o     (err_cnt_o),
    .state_o       (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor and engine model, both evaluated mid-cycle.
  always @(negedge clk) begin
    if (eng_start_o === 1'b1) begin
      if (start_cnt == 0) start_cyc = cyc;
      start_cnt++;
    end
    if (eng_clear_o === 1'b1) begin
      if (clear_cnt == 0) clear_first = cyc;
      clear_last = cyc;
      clear_cnt++;
    end
    if (job_done_o === 1'b1) begin
      jdone_cnt++;
      jdone_cyc = cyc;
    end
    if (eng_clear_o === 1'b1 && job_done_o === 1'b1) abort_cyc = cyc;
    if (busy_o === 1'b1) busy_seen = 1'b1;

    eng_done_i = 1'b0;
    if (eng_clear_o === 1'b1) begin
      eng_cnt_i = '0;
      cd = 0;
    end else if (eng_start_o === 1'b1) begin
      cd = done_delay;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && done_en) begin
        eng_done_i = 1'b1;
        eng_cnt_i  = eng_cnt_i + (spurious ? 12'd2 : 12'd1);
        spurious   = 1'b0;
      end
    end
  end

  task automatic clr_mon();
    start_cnt = 0; clear_cnt = 0; jdone_cnt = 0;
    start_cyc = -1; clear_first = -1; clear_last = -1; jdone_cyc = -1; abort_cyc = -1;
    busy_seen = 1'b0;
  endtask

  task automatic trigger(input int n, input int to, output int tc);
    @(posedge clk); #1;
    job_trigger_i = 1'b1;
    job_iters_i   = ITER_W'(n);
    timeout_i     = TO_W'(to);
    tc            = cyc;
    @(posedge clk); #1;
    job_trigger_i = 1'b0;
  endtask

  task automatic wait_job(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (jdone_cnt != 0) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (job_done_o !== 1'b0) begin fails++; $display("FAIL reset_job_done got %b exp 0", job_done_o); end
    checks++; if (iter_cnt_o !== '0) begin fails++; $display("FAIL reset_iter_cnt got %0d exp 0", iter_cnt_o); end
    checks++; if (err_timeout_o !== 1'b0 || err_cnt_o !== 1'b0) begin
      fails++; $display("FAIL reset_errors got %b%b exp 00", err_timeout_o, err_cnt_o); end
    checks++; if (eng_start_o !== 1'b0 || eng_clear_o !== 1'b0) begin
      fails++; $display("FAIL reset_eng_ctrl got %b%b exp 00", eng_start_o, eng_clear_o); end
  endtask

  task automatic test_job();
    int n, d, tc, exp_done;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? 3 : int'($urandom_range(1, 5));
      d = (k == 0) ? 5 : int'($urandom_range(1, 7));
      done_delay = d;
      clr_mon();
      trigger(n, 0, tc);
      wait_job(400, ok);
      // First start 3 cycles after trigger; each done->start gap is 2; last done->job_done is 2.
      exp_done = tc + 3 + n * d + 2 * (n - 1) + 2;
      checks++; if (!ok) begin fails++; $display("FAIL job%0d_timeout no job_done within budget", k); end
      checks++; if (start_cnt !== n) begin fails++; $display("FAIL job%0d_starts got %0d exp %0d", k, start_cnt, n); end
      checks++; if (clear_cnt !== 1 || clear_first !== tc + 1) begin
        fails++; $display("FAIL job%0d_clear got cnt %0d at %0d exp 1 at %0d", k, clear_cnt, clear_first, tc + 1); end
      checks++; if (start_cyc !== tc + 3) begin fails++; $display("FAIL job%0d_start_lat got %0d exp %0d", k, start_cyc, tc + 3); end
      checks++; if (jdone_cnt !== 1 || jdone_cyc !== exp_done) begin
        fails++; $display("FAIL job%0d_done got cnt %0d at %0d exp 1 at %0d", k, jdone_cnt, jdone_cyc, exp_done); end
      checks++; if (iter_cnt_o !== ITER_W'(n)) begin fails++; $display("FAIL job%0d_iter_cnt got %0d exp %0d", k, iter_cnt_o, n); end
      checks++; if (err_timeout_o !== 1'b0 || err_cnt_o !== 1'b0) begin
        fails++; $display("FAIL job%0d_errors got %b%b exp 00", k, err_timeout_o, err_cnt_o); end
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL job%0d_busy_after got %b exp 0", k, busy_o); end
    end
  endtask

  task automatic test_timeout();
    int tc, t, exp_abort;
    bit ok;
    t = 10;
    done_en = 1'b0;
    clr_mon();
    trigger(2, t, tc);
    wait_job(200, ok);
    // RUN starts at tc+4; expiry lands in the t-th RUN cycle, ABORT follows.
    exp_abort = tc + 4 + t;
    checks++; if (!ok) begin fails++; $display("FAIL timeout_wait no job_done within budget"); end
    checks++; if (abort_cyc !== exp_abort || jdone_cyc !== exp_abort) begin
      fails++; $display("FAIL timeout_abort got abort %0d done %0d exp %0d", abort_cyc, jdone_cyc, exp_abort); end
    checks++; if (err_timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_err got %b exp 1", err_timeout_o); end
    checks++; if (start_cnt !== 1 || clear_cnt !== 2) begin
      fails++; $display("FAIL timeout_pulses got start %0d clear %0d exp 1 2", start_cnt, clear_cnt); end
    checks++; if (iter_cnt_o !== '0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL timeout_idle got iter %0d busy %b exp 0 0", iter_cnt_o, busy_o); end
    done_en = 1'b1;
  endtask

  task automatic test_zero();
    int tc;
    clr_mon();
    trigger(0, 0, tc);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (jdone_cnt !== 1 || jdone_cyc !== tc + 1) begin
      fails++; $display("FAIL zero_done got cnt %0d at %0d exp 1 at %0d", jdone_cnt, jdone_cyc, tc + 1); end
    checks++; if (start_cnt !== 0 || clear_cnt !== 0) begin
      fails++; $display("FAIL zero_pulses got start %0d clear %0d exp 0 0", start_cnt, clear_cnt); end
    checks++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL zero_busy got %b exp 0", busy_seen); end
    checks++; if (err_timeout_o !== 1'b0) begin fails++; $display("FAIL zero_err_clear got %b exp 0", err_timeout_o); end
  endtask

  task automatic test_cnt_err();
    int tc;
    bit ok;
    done_delay = int'($urandom_range(1, 6));
    spurious = 1'b1;
    clr_mon();
    trigger(2, 0, tc);
    wait_job(200, ok);
    checks++; if (!ok || jdone_cnt !== 1) begin fails++; $display("FAIL cnt_err_done got cnt %0d exp 1", jdone_cnt); end
    checks++; if (err_cnt_o !== 1'b1) begin fails++; $display("FAIL cnt_err_flag got %b exp 1", err_cnt_o); end
    checks++; if (iter_cnt_o !== 16'd2 || err_timeout_o !== 1'b0) begin
      fails++; $display("FAIL cnt_err_iter got iter %0d to %b exp 2 0", iter_cnt_o, err_timeout_o); end
  endtask

  task automatic test_soft_clear();
    int tc, n2;
    bit ok, seen;
    done_delay = 3;
    clr_mon();
    trigger(4, 0, tc);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (iter_cnt_o == 16'd1) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL soft_first_done iter_cnt never reached 1"); end
    repeat (2) @(posedge clk);
    #1;
    clr_mon();
    soft_clear_i = 1'b1;
    tc = cyc;
    @(posedge clk); #1;
    soft_clear_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (clear_cnt !== 1 || clear_first !== tc + 1) begin
      fails++; $display("FAIL soft_clear_pulse got cnt %0d at %0d exp 1 at %0d", clear_cnt, clear_first, tc + 1); end
    checks++; if (jdone_cnt !== 0 || start_cnt !== 0) begin
      fails++; $display("FAIL soft_no_done got done %0d start %0d exp 0 0", jdone_cnt, start_cnt); end
    checks++; if (iter_cnt_o !== '0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL soft_idle got iter %0d busy %b exp 0 0", iter_cnt_o, busy_o); end

    n2 = int'($urandom_range(1, 4));
    done_delay = int'($urandom_range(1, 6));
    clr_mon();
    trigger(n2, 0, tc);
    wait_job(300, ok);
    checks++; if (!ok || jdone_cnt !== 1 || start_cnt !== n2) begin
      fails++; $display("FAIL soft_rerun got done %0d start %0d exp 1 %0d", jdone_cnt, start_cnt, n2); end
    checks++; if (iter_cnt_o !== ITER_W'(n2) || err_cnt_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      fails++; $display("FAIL soft_rerun_state got iter %0d err %b%b exp %0d 00", iter_cnt_o, err_timeout_o, err_cnt_o, n2); end
  endtask

  task automatic test_done_vs_timeout();
    int tc, t, exp_done;
    bit ok;
    t = int'($urandom_range(3, 8));
    done_delay = t;
    clr_mon();
    trigger(2, t, tc);
    repeat (4) @(posedge clk);
    #1;
    job_trigger_i = 1'b1;
    job_iters_i   = 16'd7;
    @(posedge clk); #1;
    job_trigger_i = 1'b0;
    wait_job(300, ok);
    exp_done = tc + 3 + 2 * t + 2 + 2;
    checks++; if (!ok || jdone_cyc !== exp_done) begin
      fails++; $display("FAIL race_done got %0d exp %0d", jdone_cyc, exp_done); end
    checks++; if (err_timeout_o !== 1'b0 || err_cnt_o !== 1'b0) begin
      fails++; $display("FAIL race_errors got %b%b exp 00", err_timeout_o, err_cnt_o); end
    checks++; if (iter_cnt_o !== 16'd2 || start_cnt !== 2) begin
      fails++; $display("FAIL race_iters got iter %0d start %0d exp 2 2", iter_cnt_o, start_cnt); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (jdone_cnt !== 1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL busy_trigger_ignored got done %0d busy %b exp 1 0", jdone_cnt, busy_o); end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_job();
    test_timeout();
    test_zero();
    test_cnt_err();
    test_soft_clear();
    test_done_vs_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
